// File: rtl/axi_dport_bridge_pkg.sv
// Shared types and constants for the AXI4-Lite to data-port bridge.
// Holds the FSM state encoding, AXI response codes and the default tag width.
package axi_dport_bridge_pkg;

    localparam int DPORT_TAG_W = 11;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WR_REQ   = 3'd1,
        ST_RD_REQ   = 3'd2,
        ST_WAIT_ACK = 3'd3,
        ST_RESP_B   = 3'd4,
        ST_RESP_R   = 3'd5
    } state_t;

endpackage

// File: rtl/axi_dport_bridge_hold.sv
// One-entry valid/data holding register used for the AW and W channels.
// Zero latency to hold; ready is low while full, so a new beat waits until clr_i empties it.
module axi_dport_bridge_hold #(
    parameter int W = 32
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         in_vld_i,
    input  logic [W-1:0] in_dat_i,
    input  logic         clr_i,
    output logic         rdy_o,
    output logic         held_o,
    output logic [W-1:0] dat_o
);

    logic         held_q, held_d;
    logic [W-1:0] dat_q, dat_d;

    always_comb begin
        held_d = held_q;
        dat_d  = dat_q;
        if (clr_i) begin
            held_d = 1'b0;
        end
        if (in_vld_i && !held_q) begin
            held_d = 1'b1;
            dat_d  = in_dat_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            held_q <= 1'b0;
            dat_q  <= '0;
        end else begin
            held_q <= held_d;
            dat_q  <= dat_d;
        end
    end

    assign rdy_o  = !held_q;
    assign held_o = held_q;
    assign dat_o  = dat_q;

endmodule

// File: rtl/axi_dport_bridge.sv
// AXI4-Lite responder bridging single-beat reads/writes onto the data-port request/ack bus.
// One transaction outstanding; optional ack timeout via AXI_DPORT_BRIDGE_TIMEOUT_EN.
module axi_dport_bridge
    import axi_dport_bridge_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int TAG_W          = DPORT_TAG_W
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             axi_awvalid_i,
    input  logic [31:0]      axi_awaddr_i,
    output logic             axi_awready_o,
    input  logic             axi_wvalid_i,
    input  logic [31:0]      axi_wdata_i,
    input  logic [3:0]       axi_wstrb_i,
    output logic             axi_wready_o,
    output logic             axi_bvalid_o,
    output logic [1:0]       axi_bresp_o,
    input  logic             axi_bready_i,
    input  logic             axi_arvalid_i,
    input  logic [31:0]      axi_araddr_i,
    output logic             axi_arready_o,
    output logic             axi_rvalid_o,
    output logic [31:0]      axi_rdata_o,
    output logic [1:0]       axi_rresp_o,
    input  logic             axi_rready_i,
    output logic [31:0]      mem_addr_o,
    output logic [31:0]      mem_data_wr_o,
    output logic             mem_rd_o,
    output logic [3:0]       mem_wr_o,
    output logic             mem_cacheable_o,
    output logic             mem_invalidate_o,
    output logic             mem_writeback_o,
    output logic             mem_flush_o,
    output logic [TAG_W-1:0] mem_req_tag_o,
    input  logic             mem_accept_i,
    input  logic             mem_ack_i,
    input  logic             mem_error_i,
    input  logic [31:0]      mem_data_rd_i,
    input  logic [TAG_W-1:0] mem_resp_tag_i
);

    state_t             state_q, state_d;
    logic [31:0]        ar_addr_q, ar_addr_d;
    logic               wr_q, wr_d;
    logic [1:0]         resp_q, resp_d;
    logic [31:0]        rdata_q, rdata_d;
    logic [TAG_W-1:0]   tag_q, tag_d;

    logic               aw_held, w_held;
    logic [31:0]        aw_addr;
    logic [35:0]        w_beat;
    logic               wr_issue;
    logic               ack_match;
    logic               timed_out;

    assign wr_issue = (state_q == ST_WR_REQ) && mem_accept_i;

    axi_dport_bridge_hold #(.W(32)) u_aw_hold (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .in_vld_i (axi_awvalid_i),
        .in_dat_i (axi_awaddr_i),
        .clr_i    (wr_issue),
        .rdy_o    (axi_awready_o),
        .held_o   (aw_held),
        .dat_o    (aw_addr)
    );

    axi_dport_bridge_hold #(.W(36)) u_w_hold (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .in_vld_i (axi_wvalid_i),
        .in_dat_i ({axi_wstrb_i, axi_wdata_i}),
        .clr_i    (wr_issue),
        .rdy_o    (axi_wready_o),
        .held_o   (w_held),
        .dat_o    (w_beat)
    );

    // Only the tag of the most recently accepted request completes WAIT_ACK.
    assign ack_match = mem_ack_i && (mem_resp_tag_i == tag_q - TAG_W'(1));

`ifdef AXI_DPORT_BRIDGE_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = '0;
        if (state_q == ST_WAIT_ACK) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign timed_out = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    assign timed_out = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        ar_addr_d = ar_addr_q;
        wr_d      = wr_q;
        resp_d    = resp_q;
        rdata_d   = rdata_q;
        tag_d     = tag_q;
        case (state_q)
            ST_IDLE: begin
                if (aw_held && w_held) begin
                    state_d = ST_WR_REQ;
                end else if (axi_arvalid_i) begin
                    ar_addr_d = axi_araddr_i;
                    state_d   = ST_RD_REQ;
                end
            end
            ST_WR_REQ, ST_RD_REQ: begin
                if (mem_accept_i) begin
                    tag_d   = tag_q + TAG_W'(1);
                    wr_d    = (state_q == ST_WR_REQ);
                    state_d = ST_WAIT_ACK;
                end
            end
            ST_WAIT_ACK: begin
                if (ack_match) begin
                    resp_d = mem_error_i ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
                    if (!wr_q) begin
                        rdata_d = mem_data_rd_i;
                    end
                    state_d = wr_q ? ST_RESP_B : ST_RESP_R;
                end else if (timed_out) begin
                    resp_d = AXI_RESP_SLVERR;
                    if (!wr_q) begin
                        rdata_d = '0;
                    end
                    state_d = wr_q ? ST_RESP_B : ST_RESP_R;
                end
            end
            ST_RESP_B: begin
                if (axi_bready_i) begin
                    state_d = ST_IDLE;
                end
            end
            ST_RESP_R: begin
                if (axi_rready_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= ST_IDLE;
            ar_addr_q <= '0;
            wr_q      <= 1'b0;
            resp_q    <= '0;
            rdata_q   <= '0;
            tag_q     <= '0;
        end else begin
            state_q   <= state_d;
            ar_addr_q <= ar_addr_d;
            wr_q      <= wr_d;
            resp_q    <= resp_d;
            rdata_q   <= rdata_d;
            tag_q     <= tag_d;
        end
    end

    assign axi_arready_o = (state_q == ST_IDLE) && !(aw_held && w_held);
    assign axi_bvalid_o  = (state_q == ST_RESP_B);
    assign axi_rvalid_o  = (state_q == ST_RESP_R);
    assign axi_bresp_o   = resp_q;
    assign axi_rresp_o   = resp_q;
    assign axi_rdata_o   = rdata_q;

    // Masking rather than slicing keeps the full captured address word in use.
    assign mem_addr_o    = ((state_q == ST_WR_REQ) ? aw_addr : ar_addr_q) & 32'hFFFF_FFFC;
    assign mem_data_wr_o = w_beat[31:0];
    assign mem_rd_o      = (state_q == ST_RD_REQ);
    assign mem_wr_o      = (state_q != ST_WR_REQ) ? 4'h0 :
                           (w_beat[35:32] == 4'h0) ? 4'hF : w_beat[35:32];
    assign mem_req_tag_o = tag_q;

    assign mem_cacheable_o  = 1'b0;
    assign mem_invalidate_o = 1'b0;
    assign mem_writeback_o  = 1'b0;
    assign mem_flush_o      = 1'b0;

endmodule

// File: tb/tb_axi_dport_bridge.sv
// Self-checking bench for axi_dport_bridge: scoreboarded AXI responses plus inline request checks.
module tb_axi_dport_bridge;

    localparam int TAG_W = 11;

    logic              clk_i = 1'b0;
    logic              rst_i;
    logic              axi_awvalid_i, axi_awready_o;
    logic [31:0]       axi_awaddr_i;
    logic              axi_wvalid_i, axi_wready_o;
    logic [31:0]       axi_wdata_i;
    logic [3:0]        axi_wstrb_i;
    logic              axi_bvalid_o, axi_bready_i;
    logic [1:0]        axi_bresp_o;
    logic              axi_arvalid_i, axi_arready_o;
    logic [31:0]       axi_araddr_i;
    logic              axi_rvalid_o, axi_rready_i;
    logic [31:0]       axi_rdata_o;
    logic [1:0]        axi_rresp_o;
    logic [31:0]       mem_addr_o, mem_data_wr_o;
    logic              mem_rd_o;
    logic [3:0]        mem_wr_o;
    logic              mem_cacheable_o, mem_invalidate_o, mem_writeback_o, mem_flush_o;
    logic [TAG_W-1:0]  mem_req_tag_o;
    logic              mem_accept_i, mem_ack_i, mem_error_i;
    logic [31:0]       mem_data_rd_i;
    logic [TAG_W-1:0]  mem_resp_tag_i;

    axi_dport_bridge #(.TIMEOUT_CYCLES(8), .TAG_W(TAG_W)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .axi_awvalid_i(axi_awvalid_i), .axi_awaddr_i(axi_awaddr_i), .axi_awready_o(axi_awready_o),
        .axi_wvalid_i(axi_wvalid_i), .axi_wdata_i(axi_wdata_i), .axi_wstrb_i(axi_wstrb_i),
        .axi_wready_o(axi_wready_o),
        .axi_bvalid_o(axi_bvalid_o), .axi_bresp_o(axi_bresp_o), .axi_bready_i(axi_bready_i),
        .axi_arvalid_i(axi_arvalid_i), .axi_araddr_i(axi_araddr_i), .axi_arready_o(axi_arready_o),
        .axi_rvalid_o(axi_rvalid_o), .axi_rdata_o(axi_rdata_o), .axi_rresp_o(axi_rresp_o),
        .axi_rready_i(axi_rready_i),
        .mem_addr_o(mem_addr_o), .mem_data_wr_o(mem_data_wr_o), .mem_rd_o(mem_rd_o),
        .mem_wr_o(mem_wr_o), .mem_cacheable_o(mem_cacheable_o), .mem_invalidate_o(mem_invalidate_o),
        .mem_writeback_o(mem_writeback_o), .mem_flush_o(mem_flush_o), .mem_req_tag_o(mem_req_tag_o),
        .mem_accept_i(mem_accept_i), .mem_ack_i(mem_ack_i), .mem_error_i(mem_error_i),
        .mem_data_rd_i(mem_data_rd_i), .mem_resp_tag_i(mem_resp_tag_i)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        bit          rd;
        logic [1:0]  resp;
        logic [31:0] data;
    } exp_t;

    exp_t             exp_q[$];
    int               n_cmp = 0;
    int               n_bad = 0;
    logic [TAG_W-1:0] exp_tag = '0;

    task automatic tick();
        @(posedge clk_i);
        @(negedge clk_i);
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        axi_awvalid_i = 0; axi_awaddr_i = '0; axi_wvalid_i = 0; axi_wdata_i = '0; axi_wstrb_i = '0;
        axi_bready_i = 0; axi_arvalid_i = 0; axi_araddr_i = '0; axi_rready_i = 0;
        mem_accept_i = 0; mem_ack_i = 0; mem_error_i = 0; mem_data_rd_i = '0; mem_resp_tag_i = '0;
        tick();
        tick();
        rst_i = 1'b0;
        exp_tag = '0;
    endtask

    task automatic wait_req(output bit ok);
        ok = 0;
        for (int i = 0; i < 20; i++) begin
            if (mem_rd_o || mem_wr_o != 4'h0) begin
                ok = 1;
                break;
            end
            tick();
        end
    endtask

    task automatic wait_resp(output bit ok);
        ok = 0;
        for (int i = 0; i < 40; i++) begin
            if (axi_bvalid_o || axi_rvalid_o) begin
                ok = 1;
                break;
            end
            tick();
        end
    endtask

    task automatic accept_req();
        mem_accept_i = 1;
        tick();
        mem_accept_i = 0;
        exp_tag = exp_tag + 1'b1;
    endtask

    task automatic send_ack(input logic [TAG_W-1:0] tag, input logic err, input logic [31:0] d);
        mem_ack_i = 1; mem_resp_tag_i = tag; mem_error_i = err; mem_data_rd_i = d;
        tick();
        mem_ack_i = 0; mem_error_i = 0;
    endtask

    task automatic test_reset();
        do_reset();
        tick();
        n_cmp++; if (axi_awready_o !== 1'b1) begin n_bad++; $display("FAIL rst_awready got %b want 1", axi_awready_o); end
        n_cmp++; if (axi_wready_o !== 1'b1) begin n_bad++; $display("FAIL rst_wready got %b want 1", axi_wready_o); end
        n_cmp++; if (axi_arready_o !== 1'b1) begin n_bad++; $display("FAIL rst_arready got %b want 1", axi_arready_o); end
        n_cmp++; if ({axi_bvalid_o, axi_rvalid_o, mem_rd_o} !== 3'b000) begin n_bad++; $display("FAIL rst_valids got %b want 000", {axi_bvalid_o, axi_rvalid_o, mem_rd_o}); end
        n_cmp++; if (mem_wr_o !== 4'h0) begin n_bad++; $display("FAIL rst_mem_wr got %h want 0", mem_wr_o); end
        n_cmp++; if ({axi_bresp_o, axi_rresp_o, axi_rdata_o} !== 36'h0) begin n_bad++; $display("FAIL rst_resp got %h/%h/%h want 0", axi_bresp_o, axi_rresp_o, axi_rdata_o); end
        n_cmp++; if (mem_req_tag_o !== '0) begin n_bad++; $display("FAIL rst_tag got %0d want 0", mem_req_tag_o); end
        n_cmp++; if ({mem_cacheable_o, mem_invalidate_o, mem_writeback_o, mem_flush_o} !== 4'h0) begin n_bad++; $display("FAIL tied_lines got %b want 0000", {mem_cacheable_o, mem_invalidate_o, mem_writeback_o, mem_flush_o}); end
    endtask

    task automatic test_write_basic();
        bit ok;
        exp_t e;
        axi_awvalid_i = 1; axi_awaddr_i = 32'h0000_0010;
        axi_wvalid_i = 1; axi_wdata_i = 32'hDEAD_BEEF; axi_wstrb_i = 4'hF;
        exp_q.push_back('{rd: 0, resp: 2'b00, data: 32'h0});
        tick();
        axi_awvalid_i = 0; axi_wvalid_i = 0;
        n_cmp++; if (mem_wr_o !== 4'h0) begin n_bad++; $display("FAIL wr_early got %h want 0", mem_wr_o); end
        tick();
        n_cmp++; if (mem_wr_o !== 4'hF) begin n_bad++; $display("FAIL wr_strb got %h want f", mem_wr_o); end
        n_cmp++; if (mem_addr_o !== 32'h10) begin n_bad++; $display("FAIL wr_addr got %h want 10", mem_addr_o); end
        n_cmp++; if (mem_data_wr_o !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL wr_data got %h want deadbeef", mem_data_wr_o); end
        n_cmp++; if (mem_req_tag_o !== exp_tag) begin n_bad++; $display("FAIL wr_tag got %0d want %0d", mem_req_tag_o, exp_tag); end
        accept_req();
        send_ack(exp_tag - 1'b1, 1'b0, 32'h0);
        n_cmp++; if (axi_bvalid_o !== 1'b1) begin n_bad++; $display("FAIL wr_bvalid_latency got %b want 1", axi_bvalid_o); end
        wait_resp(ok);
        n_cmp++;
        if (!ok || exp_q.size() == 0) begin
            n_bad++; $display("FAIL wr_b_timeout got no response want bvalid");
        end else begin
            e = exp_q.pop_front();
            if (axi_bvalid_o !== !e.rd || axi_bresp_o !== e.resp) begin
                n_bad++; $display("FAIL wr_bresp got v%b r%b want v1 r%b", axi_bvalid_o, axi_bresp_o, e.resp);
            end
        end
        axi_bready_i = 1; tick(); axi_bready_i = 0;
        n_cmp++; if (axi_bvalid_o !== 1'b0) begin n_bad++; $display("FAIL wr_b_drop got %b want 0", axi_bvalid_o); end
    endtask

    task automatic test_write_w_first();
        bit ok;
        exp_t e;
        int nb;
        axi_wvalid_i = 1; axi_wdata_i = 32'h1234_5678; axi_wstrb_i = 4'b0011;
        tick();
        axi_wvalid_i = 0;
        n_cmp++; if (axi_wready_o !== 1'b0) begin n_bad++; $display("FAIL w_held_ready got %b want 0", axi_wready_o); end
        tick(); tick();
        axi_awvalid_i = 1; axi_awaddr_i = 32'h0000_0022;
        exp_q.push_back('{rd: 0, resp: 2'b00, data: 32'h0});
        tick();
        axi_awvalid_i = 0;
        wait_req(ok);
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL wf_req_timeout got none want write"); end
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (mem_wr_o !== 4'b0011 || mem_addr_o !== 32'h20 || mem_data_wr_o !== 32'h1234_5678 || mem_req_tag_o !== exp_tag) begin
                n_bad++; $display("FAIL wf_stable c%0d got %h@%h d%h t%0d want 3@20 d12345678 t%0d", i, mem_wr_o, mem_addr_o, mem_data_wr_o, mem_req_tag_o, exp_tag);
            end
            tick();
        end
        accept_req();
        send_ack(exp_tag - 1'b1, 1'b0, 32'h0);
        nb = 0;
        for (int i = 0; i < 6; i++) begin
            if (axi_bvalid_o) begin
                nb++;
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    n_cmp++; if (axi_bresp_o !== e.resp) begin n_bad++; $display("FAIL wf_bresp got %b want %b", axi_bresp_o, e.resp); end
                end
                axi_bready_i = 1;
            end
            tick();
            axi_bready_i = 0;
        end
        n_cmp++; if (nb != 1) begin n_bad++; $display("FAIL wf_b_count got %0d want 1", nb); end
    endtask

    task automatic test_read_latency();
        exp_t e;
        axi_arvalid_i = 1; axi_araddr_i = 32'h0000_0046;
        exp_q.push_back('{rd: 1, resp: 2'b00, data: 32'h1357_9BDF});
        tick();
        axi_arvalid_i = 0;
        n_cmp++; if (mem_rd_o !== 1'b1) begin n_bad++; $display("FAIL rd_req_latency got %b want 1", mem_rd_o); end
        n_cmp++; if (mem_addr_o !== 32'h44) begin n_bad++; $display("FAIL rd_addr_align got %h want 44", mem_addr_o); end
        n_cmp++; if (mem_req_tag_o !== exp_tag) begin n_bad++; $display("FAIL rd_tag got %0d want %0d", mem_req_tag_o, exp_tag); end
        accept_req();
        n_cmp++; if (axi_rvalid_o !== 1'b0) begin n_bad++; $display("FAIL rd_rvalid_early got %b want 0", axi_rvalid_o); end
        send_ack(exp_tag - 1'b1, 1'b0, 32'h1357_9BDF);
        n_cmp++;
        if (axi_rvalid_o !== 1'b1 || exp_q.size() == 0) begin
            n_bad++; $display("FAIL rd_rvalid_latency got %b want 1", axi_rvalid_o);
        end else begin
            e = exp_q.pop_front();
            if (axi_rdata_o !== e.data || axi_rresp_o !== e.resp) begin
                n_bad++; $display("FAIL rd_data got %h/%b want %h/%b", axi_rdata_o, axi_rresp_o, e.data, e.resp);
            end
        end
        axi_rready_i = 1; tick(); axi_rready_i = 0;
    endtask

    task automatic test_read_error();
        bit ok;
        exp_t e;
        axi_arvalid_i = 1; axi_araddr_i = 32'h0000_0104;
        exp_q.push_back('{rd: 1, resp: 2'b10, data: 32'hCAFE_0001});
        tick();
        axi_arvalid_i = 0;
        wait_req(ok);
        n_cmp++; if (!ok || mem_rd_o !== 1'b1 || mem_addr_o !== 32'h104) begin n_bad++; $display("FAIL rderr_req got rd%b @%h want rd1 @104", mem_rd_o, mem_addr_o); end
        accept_req();
        send_ack(exp_tag - 1'b1, 1'b1, 32'hCAFE_0001);
        wait_resp(ok);
        n_cmp++;
        if (!ok || exp_q.size() == 0) begin
            n_bad++; $display("FAIL rderr_timeout got no response want rvalid");
        end else begin
            e = exp_q.pop_front();
            for (int i = 0; i < 5; i++) begin
                if (axi_rvalid_o !== 1'b1 || axi_rresp_o !== e.resp || axi_rdata_o !== e.data) begin
                    n_bad++; $display("FAIL rderr_stable c%0d got v%b %b %h want v1 %b %h", i, axi_rvalid_o, axi_rresp_o, axi_rdata_o, e.resp, e.data);
                end
                tick();
                n_cmp++;
            end
        end
        axi_rready_i = 1; tick(); axi_rready_i = 0;
        n_cmp++; if (axi_rvalid_o !== 1'b0) begin n_bad++; $display("FAIL rderr_drop got %b want 0", axi_rvalid_o); end
    endtask

    task automatic test_ar_vs_write();
        bit ok;
        exp_t e;
        do_reset();
        axi_arvalid_i = 1; axi_araddr_i = 32'h0000_0200;
        axi_awvalid_i = 1; axi_awaddr_i = 32'h0000_0300;
        axi_wvalid_i = 1; axi_wdata_i = 32'h55AA_55AA; axi_wstrb_i = 4'h0;
        exp_q.push_back('{rd: 1, resp: 2'b00, data: 32'h0BAD_F00D});
        exp_q.push_back('{rd: 0, resp: 2'b00, data: 32'h0});
        tick();
        axi_arvalid_i = 0; axi_awvalid_i = 0; axi_wvalid_i = 0;
        n_cmp++; if (mem_rd_o !== 1'b1 || mem_wr_o !== 4'h0 || mem_addr_o !== 32'h200) begin n_bad++; $display("FAIL arw_first got rd%b wr%h @%h want rd1 wr0 @200", mem_rd_o, mem_wr_o, mem_addr_o); end
        n_cmp++; if (mem_req_tag_o !== 11'd0) begin n_bad++; $display("FAIL arw_tag0 got %0d want 0", mem_req_tag_o); end
        accept_req();
        send_ack(11'd5, 1'b0, 32'hFFFF_FFFF);
        n_cmp++; if (axi_rvalid_o !== 1'b0) begin n_bad++; $display("FAIL arw_wrong_tag got rvalid %b want 0", axi_rvalid_o); end
        send_ack(11'd0, 1'b0, 32'h0BAD_F00D);
        wait_resp(ok);
        e = exp_q.pop_front();
        n_cmp++; if (!ok || axi_rvalid_o !== 1'b1 || axi_rdata_o !== e.data || axi_rresp_o !== e.resp) begin n_bad++; $display("FAIL arw_rd_resp got v%b %h %b want v1 %h %b", axi_rvalid_o, axi_rdata_o, axi_rresp_o, e.data, e.resp); end
        axi_rready_i = 1; tick(); axi_rready_i = 0;
        wait_req(ok);
        n_cmp++; if (!ok || mem_wr_o !== 4'hF || mem_addr_o !== 32'h300 || mem_data_wr_o !== 32'h55AA_55AA) begin n_bad++; $display("FAIL arw_wr_req got %h@%h d%h want f@300 d55aa55aa", mem_wr_o, mem_addr_o, mem_data_wr_o); end
        n_cmp++; if (mem_req_tag_o !== 11'd1) begin n_bad++; $display("FAIL arw_tag1 got %0d want 1", mem_req_tag_o); end
        accept_req();
        send_ack(11'd1, 1'b0, 32'h0);
        wait_resp(ok);
        e = exp_q.pop_front();
        n_cmp++; if (!ok || axi_bvalid_o !== 1'b1 || axi_bresp_o !== e.resp) begin n_bad++; $display("FAIL arw_b_resp got v%b %b want v1 %b", axi_bvalid_o, axi_bresp_o, e.resp); end
        axi_bready_i = 1; tick(); axi_bready_i = 0;
    endtask

`ifdef AXI_DPORT_BRIDGE_TIMEOUT_EN
    task automatic test_timeout();
        int waited;
        logic [TAG_W-1:0] old_tag;
        axi_arvalid_i = 1; axi_araddr_i = 32'h0000_0400;
        tick();
        axi_arvalid_i = 0;
        old_tag = exp_tag;
        accept_req();
        waited = 0;
        while (!axi_rvalid_o && waited < 40) begin
            tick();
            waited++;
        end
        n_cmp++; if (waited != 8) begin n_bad++; $display("FAIL to_cycles got %0d want 8", waited); end
        n_cmp++; if (axi_rvalid_o !== 1'b1 || axi_rresp_o !== 2'b10 || axi_rdata_o !== 32'h0) begin n_bad++; $display("FAIL to_resp got v%b %b %h want v1 10 0", axi_rvalid_o, axi_rresp_o, axi_rdata_o); end
        axi_rready_i = 1; tick(); axi_rready_i = 0;
        send_ack(old_tag, 1'b0, 32'h1111_1111);
        tick();
        n_cmp++; if (axi_rvalid_o !== 1'b0 || axi_bvalid_o !== 1'b0) begin n_bad++; $display("FAIL to_late_ack got r%b b%b want 0 0", axi_rvalid_o, axi_bvalid_o); end
    endtask
`endif

    task automatic test_reset_mid();
        bit ok;
        axi_arvalid_i = 1; axi_araddr_i = 32'h0000_0500;
        tick();
        axi_arvalid_i = 0;
        wait_req(ok);
        accept_req();
        axi_wvalid_i = 1; axi_wdata_i = 32'h7777_7777; axi_wstrb_i = 4'hF;
        tick();
        axi_wvalid_i = 0;
        rst_i = 1; tick(); rst_i = 0;
        n_cmp++; if ({axi_bvalid_o, axi_rvalid_o, mem_rd_o} !== 3'b000 || mem_wr_o !== 4'h0) begin n_bad++; $display("FAIL mid_valids got b%b r%b rd%b wr%h want all 0", axi_bvalid_o, axi_rvalid_o, mem_rd_o, mem_wr_o); end
        n_cmp++; if ({axi_awready_o, axi_wready_o, axi_arready_o} !== 3'b111) begin n_bad++; $display("FAIL mid_readies got %b want 111", {axi_awready_o, axi_wready_o, axi_arready_o}); end
        n_cmp++; if (mem_req_tag_o !== '0) begin n_bad++; $display("FAIL mid_tag got %0d want 0", mem_req_tag_o); end
        exp_tag = '0;
        send_ack(exp_tag - 1'b1, 1'b0, 32'h2222_2222);
        n_cmp++; if (axi_rvalid_o !== 1'b0) begin n_bad++; $display("FAIL mid_stray_ack got %b want 0", axi_rvalid_o); end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_write_basic();
        test_write_w_first();
        test_read_latency();
        test_read_error();
        test_ar_vs_write();
`ifdef AXI_DPORT_BRIDGE_TIMEOUT_EN
        test_timeout();
`endif
        test_reset_mid();
        n_cmp++; if (exp_q.size() != 0) begin n_bad++; $display("FAIL scoreboard_leftover got %0d want 0", exp_q.size()); end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/axi_dport_bridge.md
# axi_dport_bridge

AXI4-Lite responder that turns single-beat AXI4-Lite reads and writes into transactions on the core's simple data-port request/ack interface (address, byte write strobes, read strobe, accept, ack, tag). It is the slave-to-master counterpart of the data-port AXI initiator. It lets an external AXI master, such as a debug host or DMA, reach any data-port target: a TCM port or a `dport_mux` input. One transaction is outstanding at a time.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 1024: maximum number of cycles spent waiting for an ack (used only with the timeout feature).
- `TAG_W`, default 11: width of the request/response tag.

Ports (clock and reset first). Clock is `clk_i`; reset is `rst_i`, synchronous, active-high.
- `clk_i` in 1: clock.
- `rst_i` in 1: synchronous, active-high reset.
- `axi_awvalid_i` in 1; `axi_awaddr_i` in 32; `axi_awready_o` out 1: write-address channel.
- `axi_wvalid_i` in 1; `axi_wdata_i` in 32; `axi_wstrb_i` in 4; `axi_wready_o` out 1: write-data channel.
- `axi_bvalid_o` out 1; `axi_bresp_o` out 2; `axi_bready_i` in 1: write-response channel.
- `axi_arvalid_i` in 1; `axi_araddr_i` in 32; `axi_arready_o` out 1: read-address channel.
- `axi_rvalid_o` out 1; `axi_rdata_o` out 32; `axi_rresp_o` out 2; `axi_rready_i` in 1: read-data channel.
- `mem_addr_o` out 32: word-aligned request address, `{addr[31:2],2'b00}`.
- `mem_data_wr_o` out 32: write data.
- `mem_rd_o` out 1: read request.
- `mem_wr_o` out 4: byte write strobes; nonzero means a write request.
- `mem_cacheable_o`, `mem_invalidate_o`, `mem_writeback_o`, `mem_flush_o` out 1 each: tied to 0.
- `mem_req_tag_o` out `TAG_W`: request tag.
- `mem_accept_i` in 1: target accepted the request this cycle.
- `mem_ack_i` in 1; `mem_error_i` in 1; `mem_data_rd_i` in 32; `mem_resp_tag_i` in `TAG_W`: response.

## Operation
- **AW holding register.** One entry. `axi_awready_o = !aw_held`. It loads on handshake and clears when the write request is accepted.
- **W holding register.** One entry, handled independently of AW. `axi_wready_o = !w_held`. It loads on handshake and clears when the write request is accepted.
- **State machine.** States are IDLE, WR_REQ, RD_REQ, WAIT_ACK, RESP_B and RESP_R.
- **IDLE.**
  - `axi_arready_o = !(aw_held && w_held)`, so a complete write has priority.
  - If `aw_held && w_held`, go to WR_REQ.
  - Otherwise, on an AR handshake, capture the address and go to RD_REQ.
- **WR_REQ.** Drive `mem_wr_o = wstrb` (forced to 4'hF when `wstrb == 0`, so that a write request is always issued), `mem_data_wr_o = wdata` and `mem_addr_o`. Hold all of these until `mem_accept_i`, then go to WAIT_ACK.
- **RD_REQ.** Drive `mem_rd_o = 1` and hold until `mem_accept_i`, then go to WAIT_ACK.
- **Tags.**
  - `mem_req_tag_o` is the value of `tag_q`.
  - `tag_q` increments (mod 2^`TAG_W`) on every accept.
  - In WAIT_ACK, an ack counts only when `mem_resp_tag_i == tag_q - 1`; all other acks are ignored.
- **WAIT_ACK.**
  - On a matching ack, latch `resp = mem_error_i ? 2'b10 : 2'b00` (SLVERR/OKAY) and, for reads, latch `mem_data_rd_i`.
  - Then go to RESP_B for a write or RESP_R for a read.
- **RESP_B.** `axi_bvalid_o = 1`; leave when `axi_bready_i` is high, returning to IDLE.
- **RESP_R.** `axi_rvalid_o = 1`; leave when `axi_rready_i` is high, returning to IDLE.
- **Output stability.** All response outputs hold stable while their valid is high and not yet handshaken.
- **Acks outside WAIT_ACK.** Ignored, never buffered.

## Timing
- **Reset values.** All `*valid_o` and `mem_rd_o` are 0; `mem_wr_o` is 0; `bresp`/`rresp` are 0; `rdata` is 0; `tag_q` is 0; state is IDLE; both holding registers are empty.
  - `axi_awready_o` = 1, `axi_wready_o` = 1 and `axi_arready_o` = 1 in the cycle after reset.
- **Reset mid-transaction.** Abandons the transaction with no AXI response, and the tag restarts at 0.
- **Read latency.** AR handshake in cycle 0; `mem_rd_o` in cycle 1; with immediate accept and an ack in cycle 2, `rvalid` in cycle 3.
- **Write latency.** AW and W both held at the end of cycle 0; WR_REQ in cycle 1; accept in 1, ack in 2, `bvalid` in 3.
- **Ack timing.** An ack in the same cycle as accept is not recognised. The target acks at least one cycle later.
- **AW/W ordering.** AW and W may arrive in any order and in different cycles. Once a new beat has been held it is not re-accepted until the previous write has been issued.
- **Simultaneous AR and completion of AW+W in cycle 0.** AR wins, because the holding registers were not yet both full; the write follows after the read response.

## Configuration
- **`AXI_DPORT_BRIDGE_TIMEOUT_EN` defined:**
  - A counter runs in WAIT_ACK.
  - After `TIMEOUT_CYCLES` cycles without a matching ack, the response is SLVERR; a read returns `rdata = 0`.
  - The counter clears on entry to WAIT_ACK.
  - The stale tag guarantees that a late ack is discarded.
- **Undefined:** WAIT_ACK waits indefinitely and no counter logic exists.

## Structure
- The shared package holds:
  - the state enum;
  - the `AXI_RESP_OKAY`/`AXI_RESP_SLVERR` constants;
  - the default tag width.
- Natural sub-module: `axi_dport_bridge_hold`, a one-entry valid/data holding register instanced for AW and for W.

## Test plan
- Write AW=0x0000_0010, W=0xDEADBEEF strb 4'hF; target accepts immediately and acks one cycle later → `mem_wr_o` = 4'hF at address 0x10, then `bvalid` with `bresp` 2'b00.
- W presented 3 cycles before AW, strb 4'b0011; target holds `accept` low for 4 cycles → request stable throughout, `mem_wr_o` = 4'b0011, a single B response.
- Read 0x0000_0104 with `mem_error_i = 1` on ack → `mem_addr_o` = 0x104, `rresp` 2'b10; `rready` held low for 5 cycles → `rdata`/`rresp` stable.
- AR and complete AW+W in the same cycle → read issued first, write issued next; tags are 0 then 1; an ack carrying wrong tag 5 is ignored.
- With `AXI_DPORT_BRIDGE_TIMEOUT_EN` and `TIMEOUT_CYCLES = 8`, the target never acks a read → `rvalid` after 8 wait cycles, SLVERR, `rdata` 0; a later ack with the old tag is dropped.
- `rst_i` asserted in WAIT_ACK → next cycle all valids are 0, `awready`/`wready`/`arready` are 1 and the tag is 0.
